// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The IF/ID payload struct is sized by ADDR_W_DEFAULT, so instances must keep ADDR_W <= ADDR_W_DEFAULT.
package fetch_pkg;

    localparam int ADDR_W_DEFAULT = 64;
    localparam int INSTR_W        = 32;
    localparam int INSTR_BYTES    = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]        instr;
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic [ADDR_W_DEFAULT-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect / +4 / hold next-PC selection
// and the legality check for the current fetch address.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEFAULT,
    parameter longint unsigned    IMEM_SIZE = 256,
    parameter logic [ADDR_W-1:0]  PC_RESET  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_legal
);

    // Highest byte address at which a full word still fits inside the memory.
    localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(IMEM_SIZE - INSTR_BYTES);

    logic [ADDR_W-1:0] pc_next;

    assign pc_plus4 = pc + ADDR_W'(INSTR_BYTES);
    assign pc_legal = (pc[1:0] == 2'b00) && (pc <= LAST_LEGAL);

    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the combinational instruction memory from the PC and
// captures instructions into an IF/ID register with a valid/ready handshake.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEFAULT,
    parameter longint unsigned   IMEM_SIZE = 256,
    parameter logic [ADDR_W-1:0] PC_RESET  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_adr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc,
    output logic [31:0]        fetch_count
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    if_id_t            if_id_q;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pc_legal;
    logic              slot_free;
    logic              fetch_en;
    logic              fault_enter;

    fetch_pc_reg #(
        .ADDR_W    (ADDR_W),
        .IMEM_SIZE (IMEM_SIZE),
        .PC_RESET  (PC_RESET)
    ) u_pc (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (fetch_en),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .pc_legal        (pc_legal)
    );

    assign imem_adr  = pc;
    assign slot_free = !out_valid || out_ready;

    // Redirect outranks everything: it neither fetches nor faults in its own cycle.
    assign fetch_en    = (state_q == RUN) && !redirect_valid && slot_free && pc_legal;
    assign fault_enter = (state_q == RUN) && !redirect_valid && slot_free && !pc_legal;

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (fault_enter) begin
            state_d = FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign fault = (state_q == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_pc <= '0;
        end else if (fault_enter) begin
            fault_pc <= pc;
        end
    end

    // The held entry drains on a transfer edge even when nothing new is fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            if_id_q   <= '0;
        end else if (redirect_valid) begin
            out_valid <= 1'b0;
        end else if (fetch_en) begin
            out_valid        <= 1'b1;
            if_id_q.instr    <= imem_instr;
            if_id_q.pc       <= ADDR_W_DEFAULT'(pc);
            if_id_q.pc_plus4 <= ADDR_W_DEFAULT'(pc_plus4);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_instr    = if_id_q.instr;
    assign out_pc       = if_id_q.pc[ADDR_W-1:0];
    assign out_pc_plus4 = if_id_q.pc_plus4[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (fetch_en && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 16-byte combinational memory.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 64;

    localparam logic [31:0] W0 = 32'h8B1F03E5;
    localparam logic [31:0] W1 = 32'hF84000A4;
    localparam logic [31:0] W2 = 32'h91000421;
    localparam logic [31:0] W3 = 32'hD65F03C0;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_adr;
    logic [31:0]       imem_instr;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_plus4;
    logic              fault;
    logic [ADDR_W-1:0] fault_pc;
    logic [31:0]       fetch_count;

    int tests_run;
    int tests_failed;

    instruction_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .IMEM_SIZE (16),
        .PC_RESET  (64'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_adr        (imem_adr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .fault           (fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-indexed memory; addresses outside the 16 bytes return a marker word.
    always_comb begin
        imem_instr = 32'hDEAD_BEEF;
        case (imem_adr)
            64'd0:  imem_instr = W0;
            64'd4:  imem_instr = W1;
            64'd8:  imem_instr = W2;
            64'd12: imem_instr = W3;
            default: imem_instr = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b1;

        // Reset state
        #12;
        check("rst_adr",    imem_adr,    64'd0);
        check("rst_valid",  out_valid,   64'd0);
        check("rst_instr",  out_instr,   64'd0);
        check("rst_fault",  fault,       64'd0);
        check("rst_count",  fetch_count, 64'd0);
        rst_n = 1'b1;

        // Back-to-back fetch
        step();
        check("e1_instr",  out_instr,    W0);
        check("e1_pc",     out_pc,       64'd0);
        check("e1_pc4",    out_pc_plus4, 64'd4);
        check("e1_valid",  out_valid,    64'd1);
        step();
        check("e2_instr",  out_instr,    W1);
        check("e2_pc",     out_pc,       64'd4);
        check("e2_count",  fetch_count,  64'd2);

        // Stall after first fetch
        do_reset();
        step();
        check("s0_pc", out_pc, 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",    out_pc,      64'd0);
            check("stall_adr",   imem_adr,    64'd4);
            check("stall_count", fetch_count, 64'd1);
            check("stall_valid", out_valid,   64'd1);
        end
        out_ready = 1'b1;
        step();
        check("unstall_pc",    out_pc,    64'd4);
        check("unstall_instr", out_instr, W1);
        step();
        check("pre_redir_pc",  out_pc,      64'd8);
        check("pre_redir_cnt", fetch_count, 64'd3);

        // Redirect flushes the held entry even with out_ready=1
        redirect_valid  = 1'b1;
        redirect_target = 64'd0;
        step();
        check("redir_valid", out_valid,   64'd0);
        check("redir_adr",   imem_adr,    64'd0);
        check("redir_count", fetch_count, 64'd3);
        redirect_valid = 1'b0;
        step();
        check("post_redir_pc",    out_pc,    64'd0);
        check("post_redir_instr", out_instr, W0);
        check("post_redir_valid", out_valid, 64'd1);

        // Free run to the end of memory
        step();
        check("run_pc4",  out_pc, 64'd4);
        step();
        check("run_pc8",  out_pc, 64'd8);
        step();
        check("run_pc12",    out_pc,       64'd12);
        check("run_pc12_p4", out_pc_plus4, 64'd16);
        check("run_instr12", out_instr,    W3);
        check("run_adr16",   imem_adr,     64'd16);
        check("run_count",   fetch_count,  64'd7);
        check("run_nofault", fault,        64'd0);
        step();
        check("oor_fault",   fault,       64'd1);
        check("oor_fpc",     fault_pc,    64'd16);
        check("oor_valid",   out_valid,   64'd0);
        check("oor_adr",     imem_adr,    64'd16);
        check("oor_count",   fetch_count, 64'd7);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_fault", fault,     64'd1);
            check("hold_valid", out_valid, 64'd0);
            check("hold_adr",   imem_adr,  64'd16);
        end

        // Redirect out of FAULT to a misaligned target
        redirect_valid  = 1'b1;
        redirect_target = 64'd6;
        step();
        check("mis_redir_fault", fault,    64'd0);
        check("mis_redir_adr",   imem_adr, 64'd6);
        check("mis_redir_fpc",   fault_pc, 64'd16);
        redirect_valid = 1'b0;
        step();
        check("mis_fault", fault,     64'd1);
        check("mis_fpc",   fault_pc,  64'd6);
        check("mis_valid", out_valid, 64'd0);
        redirect_valid  = 1'b1;
        redirect_target = 64'd0;
        step();
        check("resume_fault", fault,    64'd0);
        check("resume_adr",   imem_adr, 64'd0);
        redirect_valid = 1'b0;
        step();
        check("resume_pc",    out_pc,      64'd0);
        check("resume_valid", out_valid,   64'd1);
        check("resume_count", fetch_count, 64'd8);

        // Last legal word is fetched, the next address faults
        redirect_valid  = 1'b1;
        redirect_target = 64'd12;
        step();
        redirect_valid = 1'b0;
        step();
        check("edge_pc",    out_pc,    64'd12);
        check("edge_instr", out_instr, W3);
        check("edge_fault", fault,     64'd0);
        step();
        check("edge_oor_fault", fault,    64'd1);
        check("edge_oor_fpc",   fault_pc, 64'd16);

        // Asynchronous reset mid-stall
        redirect_valid  = 1'b1;
        redirect_target = 64'd0;
        step();
        redirect_valid = 1'b0;
        step();
        out_ready = 1'b0;
        step();
        check("pre_arst_valid", out_valid, 64'd1);
        check("pre_arst_adr",   imem_adr,  64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid,   64'd0);
        check("arst_fault", fault,       64'd0);
        check("arst_fpc",   fault_pc,    64'd0);
        check("arst_adr",   imem_adr,    64'd0);
        check("arst_count", fetch_count, 64'd0);
        #20;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
